hw_accel_stream_host: RTL and testbench
=======================================

# hw_accel_stream_host

Host-side counterpart of the hardware-accelerator wrapper. It acts as the register initiator and as both DMA stream endpoints. For each frame it programs the Sobel threshold and mode, then arms every DMA output transfer with an init_done 0→1 edge. It streams grayscale source pixels into the accelerator's read channel and collects the processed pixels from its write channel, checking transfer boundaries. It is used in the standalone accelerator testbed and in the camera path where no memory DMA is present. The accelerator register port runs on clk.

## Interface
- DATA_WIDTH, 32, stream/register data width (4 bytes)
- AXI_ADDR_WIDTH, 32, register address width
- FRAME_WIDTH, 640, pixels per line
- FRAME_HEIGHT, 480, lines per frame
- DMA_TRANSFER_LENGTH, 1920, words per output transfer (L); must divide FRAME_WIDTH*FRAME_HEIGHT (N)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle frame start; ignored while busy
- cfg_thresh  in  8  Sobel threshold, sampled on accepted start
- cfg_mode  in  2  accelerator mode, sampled on accepted start
- src_valid / src_ready  in/out  1  source pixel handshake
- src_pixel  in  8  source grayscale pixel
- reg_we  out  1  register write strobe, one cycle per write
- reg_waddr  out  AXI_ADDR_WIDTH  byte address
- reg_wdata  out  DATA_WIDTH  write data
- rvalid / rready  out/in  1  read-channel handshake into accelerator
- rkeep  out  4  byte keep
- rdata  out  DATA_WIDTH  {24'd0, pixel}
- wvalid / wready  in/out  1  write-channel handshake from accelerator
- wlast  in  1  last word of transfer
- wdata  in  DATA_WIDTH  processed word; pixel in [7:0]
- descriptor_updated  out  1  one-cycle pulse per completed transfer
- snk_valid  out  1  processed pixel valid
- snk_pixel  out  8  processed pixel
- snk_ready  in  1  sink can accept
- busy  out  1  high from accepted start to frame_done
- frame_done  out  1  one-cycle pulse
- err_wlast  out  1  sticky wlast mismatch flag

## Operation
- FSM states: IDLE, CFG_T, CFG_M, CLR, ARM, RUN, DONE.
- IDLE: start=1 latches cfg, clears in_cnt/out_cnt/xfer_cnt and err_wlast, then moves to CFG_T.
- CFG_T writes addr 0x00 with {24'd0,thresh}. CFG_M writes 0x04 with {30'd0,mode}. CLR writes 0x08 with 0. ARM writes 0x08 with 1.
- Each of these states lasts one cycle with reg_we=1. ARM→RUN.
- Input path is active in CLR, ARM, RUN while in_cnt<N.
  - One-entry output register: src_ready = active && in_cnt<N && (~rvalid || rready).
  - Source beat loads rdata/rvalid and increments in_cnt.
  - rvalid&&rready with no new load drops rvalid.
- Output path: wready = (state==RUN) && snk_ready.
  - An accepted word (wvalid&&wready) increments out_cnt and xfer_cnt.
  - Next cycle: snk_valid=1, snk_pixel=wdata[7:0]. The sink must accept every beat from a cycle in which it drove snk_ready=1.
- Transfer end: on the accepted word with xfer_cnt==L-1:
  - xfer_cnt wraps to 0 and descriptor_updated pulses next cycle.
  - If out_cnt+1<N go to CLR (re-arm); else go to DONE.
- wlast check: wlast asserted on an accepted word at xfer_cnt≠L-1, or deasserted at xfer_cnt==L-1, sets err_wlast. err_wlast holds until the next accepted start; counting continues on L regardless.
- DONE: frame_done=1 for one cycle, then IDLE. The input path has completed by then, since the output cannot exceed the input.
- Counters: in_cnt/out_cnt are $clog2(N+1) bits; xfer_cnt is $clog2(L) bits. Neither ever exceeds N.

## Timing
- Reset values:
  - rkeep=4'hF, constant.
  - All other outputs 0, including reg_waddr/reg_wdata/rdata/snk_pixel.
  - FSM in IDLE, counters 0.
- Start→first reg_we: 1 cycle. Four writes follow on consecutive cycles; RUN is entered the cycle after ARM.
- Re-arm gap: 2 cycles (CLR, ARM) with wready=0; the input path keeps flowing.
- wvalid accept→snk_valid: 1 cycle. Accept of word L-1→descriptor_updated: 1 cycle.
- Last accepted word→frame_done: 2 cycles (DONE state), busy falls with frame_done.
- start while busy: no effect.
- start and rst together: rst wins.
- rst mid-operation: immediate return to reset values. Partial frame discarded, no frame_done.

## Test plan
- Register sequence: start with cfg_thresh=0x50, cfg_mode=1 → reg writes (0x00,0x50), (0x04,1), (0x08,0), (0x08,1) on 4 consecutive cycles; busy=1.
- Loopback frame, W=8, H=4, L=8, ideal accelerator model → 32 rdata beats in source order, 4 descriptor_updated pulses, 3 CLR/ARM re-arm pairs, 32 snk_valid, one frame_done, err_wlast=0.
- Random 50% rready low → no pixel lost or reordered; src_ready low whenever rvalid is held; in_cnt stops at 32.
- wlast asserted on word 5 of transfer 0 → err_wlast=1 and stays 1; descriptor_updated still fires after word 8; frame completes.
- snk_ready low for 10 cycles in RUN → wready=0 and no snk_valid in those cycles; stream resumes with no loss.
- rst asserted at out_cnt=12 → all outputs at reset values, no frame_done; new start gives a clean full frame with 4 descriptor pulses.

Source files
------------

// File: rtl/hw_accel_stream_host.sv
// hw_accel_stream_host: programs the Sobel accelerator per frame and acts as both DMA stream endpoints.
module hw_accel_stream_host #(
  parameter int DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int FRAME_WIDTH = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int DMA_TRANSFER_LENGTH = 1920
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                cfg_thresh,
  input  logic [1:0]                cfg_mode,
  input  logic                      src_valid,
  output logic                      src_ready,
  input  logic [7:0]                src_pixel,
  output logic                      reg_we,
  output logic [AXI_ADDR_WIDTH-1:0] reg_waddr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [3:0]                rkeep,
  output logic [DATA_WIDTH-1:0]     rdata,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic                      wlast,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic                      descriptor_updated,
  output logic                      snk_valid,
  output logic [7:0]                snk_pixel,
  input  logic                      snk_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err_wlast
);
  localparam int N = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int L = DMA_TRANSFER_LENGTH;
  localparam int CW = $clog2(N + 1);
  localparam int XW = $clog2(L);
  localparam logic [CW-1:0] N_C = CW'(N);
  localparam logic [CW-1:0] NM1 = CW'(N - 1);
  localparam logic [XW-1:0] LM1 = XW'(L - 1);
  localparam logic [2:0] IDLE = 3'd0, CFG_T = 3'd1, CFG_M = 3'd2, CLR = 3'd3, ARM = 3'd4, RUN = 3'd5, DONE = 3'd6;
  logic [2:0] state;
  logic [7:0] thresh_q;
  logic [1:0] mode_q;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [XW-1:0] xfer_cnt;
  logic active, src_fire, w_fire, xfer_end, w_unused;
  assign active = state == CLR || state == ARM || state == RUN;
  assign src_ready = active && in_cnt < N_C && (!rvalid || rready);
  assign src_fire = src_valid && src_ready;
  assign wready = state == RUN && snk_ready;
  assign w_fire = wvalid && wready;
  assign xfer_end = xfer_cnt == LM1;
  assign rkeep = 4'hF;
  assign busy = state != IDLE;
  assign reg_we = state == CFG_T || state == CFG_M || state == CLR || state == ARM;
  assign reg_waddr = state == CFG_T ? '0 : state == CFG_M ? AXI_ADDR_WIDTH'(4) : reg_we ? AXI_ADDR_WIDTH'(8) : '0;
  assign reg_wdata = state == CFG_T ? DATA_WIDTH'(thresh_q) : state == CFG_M ? DATA_WIDTH'(mode_q) :
                     state == ARM ? DATA_WIDTH'(1) : '0;
  assign w_unused = ^wdata[DATA_WIDTH-1:8];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      thresh_q <= '0;
      mode_q <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
      xfer_cnt <= '0;
      rvalid <= 1'b0;
      rdata <= '0;
      descriptor_updated <= 1'b0;
      snk_valid <= 1'b0;
      snk_pixel <= '0;
      frame_done <= 1'b0;
      err_wlast <= 1'b0;
    end else begin
      descriptor_updated <= w_fire && xfer_end;
      snk_valid <= w_fire;
      frame_done <= state == DONE;
      if (w_fire) snk_pixel <= wdata[7:0];
      // one-entry read buffer: a new beat may replace the one being consumed this cycle
      if (src_fire) begin
        rvalid <= 1'b1;
        rdata <= DATA_WIDTH'(src_pixel);
        in_cnt <= in_cnt + 1'b1;
      end else if (rready) rvalid <= 1'b0;
      if (w_fire) begin
        out_cnt <= out_cnt + 1'b1;
        xfer_cnt <= xfer_end ? '0 : xfer_cnt + 1'b1;
        if (wlast != xfer_end) err_wlast <= 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state <= CFG_T;
          thresh_q <= cfg_thresh;
          mode_q <= cfg_mode;
          in_cnt <= '0;
          out_cnt <= '0;
          xfer_cnt <= '0;
          err_wlast <= 1'b0;
        end
        CFG_T: state <= CFG_M;
        CFG_M: state <= CLR;
        CLR: state <= ARM;
        ARM: state <= RUN;
        RUN: if (w_fire && xfer_end) state <= out_cnt < NM1 ? CLR : DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hw_accel_stream_host.sv
// tb_hw_accel_stream_host: drives the host against an ideal accelerator model and checks streams, registers and pulses.
module tb_hw_accel_stream_host;
  localparam int W = 8, H = 4, L = 8, N = W * H;
  logic clk = 1'b0, rst, start, src_valid, src_ready, reg_we, rvalid, rready, wvalid, wready, wlast;
  logic descriptor_updated, snk_valid, snk_ready, busy, frame_done, err_wlast;
  logic [7:0] cfg_thresh, src_pixel, snk_pixel;
  logic [1:0] cfg_mode;
  logic [31:0] reg_waddr, reg_wdata, rdata, wdata;
  logic [3:0] rkeep;

  hw_accel_stream_host #(.DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .FRAME_WIDTH(W), .FRAME_HEIGHT(H),
                         .DMA_TRANSFER_LENGTH(L)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_thresh(cfg_thresh), .cfg_mode(cfg_mode),
    .src_valid(src_valid), .src_ready(src_ready), .src_pixel(src_pixel),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .rvalid(rvalid), .rready(rready), .rkeep(rkeep), .rdata(rdata),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .descriptor_updated(descriptor_updated), .snk_valid(snk_valid), .snk_pixel(snk_pixel),
    .snk_ready(snk_ready), .busy(busy), .frame_done(frame_done), .err_wlast(err_wlast));

  always #5 clk = ~clk;

  typedef struct {
    logic start; logic [7:0] thr; logic [1:0] mode;
    logic we; logic [31:0] addr; logic [31:0] data; logic bsy;
  } reg_vec_t;
  reg_vec_t tv[5];

  localparam logic [116:0] RST_OUTS = {1'b0, 32'd0, 32'd0, 1'b0, 4'hF, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  byte unsigned src_q[$], rd_exp[$], acc_q[$], snk_exp[$];
  int n_vec = 0, n_err = 0;
  int acc_out, n_in, n_desc, n_arm, n_fd, n_snk, fd_timer, gap, snk_block, bad_idx, rr_pct;
  bit err_m, desc_m, snkv_m, running;

  function automatic logic [116:0] outs();
    return {reg_we, reg_waddr, reg_wdata, rvalid, rkeep, rdata, wready, descriptor_updated, snk_valid,
            snk_pixel, busy, frame_done, err_wlast, src_ready};
  endfunction

  function automatic logic [7:0] proc(logic [7:0] p);
    return p * 8'd3 + 8'd7;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // one clock of the ideal accelerator and reference model
  task automatic cycle();
    bit s_f, r_f, w_f, w_end;
    logic [7:0] rpix, wpix;
    @(negedge clk);
    chk("snk_valid", snk_valid, snkv_m);
    if (snk_valid) begin
      n_snk++;
      if (snk_exp.size() == 0) chk("snk_extra", 1, 0);
      else chk("snk_pixel", snk_pixel, snk_exp.pop_front());
    end
    chk("descriptor_updated", descriptor_updated, desc_m);
    chk("err_wlast", err_wlast, err_m);
    chk("frame_done", frame_done, fd_timer == 2);
    chk("busy", busy, running && fd_timer < 2);
    if (descriptor_updated) n_desc++;
    if (frame_done) n_fd++;
    if (reg_we && reg_waddr == 32'h8 && reg_wdata == 32'h1) n_arm++;
    if (fd_timer >= 2) running = 0;
    start = 1'b0;
    src_valid = src_q.size() > 0 && $urandom_range(0, 3) != 0;
    src_pixel = src_q.size() > 0 ? src_q[0] : 8'h00;
    rready = $urandom_range(0, 99) < rr_pct;
    snk_ready = snk_block > 0 ? 1'b0 : $urandom_range(0, 4) != 0;
    wvalid = acc_q.size() > 0;
    wpix = wvalid ? proc(acc_q[0]) : 8'h00;
    wdata = {24'd0, wpix};
    w_end = acc_out % L == L - 1;
    wlast = w_end ^ (acc_out == bad_idx);
    #1;
    if (rvalid && !rready) chk("src_ready_hold", src_ready, 0);
    if (n_in >= N) chk("src_ready_full", src_ready, 0);
    if (snk_block > 0 || gap > 0) chk("wready_off", wready, 0);
    s_f = src_valid && src_ready;
    r_f = rvalid && rready;
    w_f = wvalid && wready;
    rpix = rdata[7:0];
    @(posedge clk);
    if (r_f) begin
      if (rd_exp.size() == 0) chk("rdata_extra", 1, 0);
      else chk("rdata", rdata, {24'd0, rd_exp.pop_front()});
      acc_q.push_back(rpix);
    end
    if (s_f) begin
      rd_exp.push_back(src_q.pop_front());
      n_in++;
    end
    if (fd_timer > 0) fd_timer++;
    if (gap > 0) gap--;
    if (snk_block > 0) snk_block--;
    snkv_m = w_f;
    desc_m = w_f && w_end;
    if (w_f) begin
      void'(acc_q.pop_front());
      snk_exp.push_back(wpix);
      if (wlast != w_end) err_m = 1;
      if (acc_out == N - 1) fd_timer = 1;
      else if (w_end) gap = 2;
      acc_out++;
    end
  endtask

  task automatic new_frame(int bad);
    src_q.delete();
    repeat (N + 4) src_q.push_back(8'($urandom));
    n_in = 0; n_desc = 0; n_arm = 0; n_fd = 0; n_snk = 0; acc_out = 0; bad_idx = bad;
  endtask

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1; cfg_thresh = 8'($urandom); cfg_mode = 2'($urandom); src_valid = 1'b0; wvalid = 1'b0;
    @(posedge clk);
    running = 1; fd_timer = 0; err_m = 0; desc_m = 0; snkv_m = 0; gap = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; src_valid = 1'b0; wvalid = 1'b0;
    #1 chk("rst_async_outs", outs(), RST_OUTS);
    @(posedge clk);
    #1 chk("rst_with_start_outs", outs(), RST_OUTS);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    src_q.delete(); rd_exp.delete(); acc_q.delete(); snk_exp.delete();
    running = 0; fd_timer = 0; err_m = 0; desc_m = 0; snkv_m = 0; gap = 0; snk_block = 0; acc_out = 0; n_fd = 0;
    repeat (4) cycle();
    chk("rst_no_frame_done", n_fd, 0);
  endtask

  task automatic run_frame(int rst_at, int blk_at, bit exp_err);
    int budget = 0;
    bit blk_used = 0;
    while (fd_timer < 3 && budget < 3000) begin
      if (rst_at >= 0 && acc_out >= rst_at) begin
        do_reset();
        return;
      end
      if (blk_at >= 0 && acc_out >= blk_at && !blk_used) begin
        snk_block = 10;
        blk_used = 1;
      end
      cycle();
      budget++;
    end
    chk("frame_timeout", budget < 3000, 1);
    chk("in_count", n_in, N);
    chk("src_leftover", src_q.size(), 4);
    chk("desc_count", n_desc, N / L);
    chk("arm_count", n_arm, N / L);
    chk("frame_done_count", n_fd, 1);
    chk("snk_count", n_snk, N);
    chk("snk_pending", snk_exp.size(), 0);
    chk("err_final", err_wlast, exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 8'h50, 2'd1, 1'b1, 32'h0, 32'h50, 1'b1};
    tv[1] = '{1'b0, 8'h00, 2'd0, 1'b1, 32'h4, 32'h1, 1'b1};
    tv[2] = '{1'b1, 8'hAA, 2'd2, 1'b1, 32'h8, 32'h0, 1'b1};
    tv[3] = '{1'b0, 8'h00, 2'd0, 1'b1, 32'h8, 32'h1, 1'b1};
    tv[4] = '{1'b0, 8'h00, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1};
    rst = 1'b1; start = 1'b0; cfg_thresh = '0; cfg_mode = '0; src_valid = 1'b0; src_pixel = '0;
    rready = 1'b0; wvalid = 1'b0; wlast = 1'b0; wdata = '0; snk_ready = 1'b1;
    rr_pct = 100; snk_block = 0; gap = 0; fd_timer = 0; running = 0; err_m = 0; desc_m = 0; snkv_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), RST_OUTS);
    rst = 1'b0;
    new_frame(-1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = tv[i].start; cfg_thresh = tv[i].thr; cfg_mode = tv[i].mode; snk_ready = 1'b1;
      @(posedge clk);
      #1 chk($sformatf("reg_seq%0d", i), {reg_we, reg_waddr, reg_wdata, busy},
             {tv[i].we, tv[i].addr, tv[i].data, tv[i].bsy});
    end
    running = 1; n_arm = 1;
    run_frame(-1, -1, 0);
    rr_pct = 50;
    new_frame(-1); start_frame(); run_frame(-1, 10, 0);
    rr_pct = 80;
    new_frame(4); start_frame(); run_frame(-1, -1, 1);
    new_frame(-1); start_frame(); run_frame(12, -1, 0);
    rr_pct = 60;
    new_frame(-1); start_frame(); run_frame(-1, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
